// File: rtl/step_debounce.sv
// ============================================================================
//  Module   : step_debounce
//  Purpose  : Synchronise and debounce a raw button, emitting one step pulse
//             per press plus optional auto-repeat pulses while held.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module step_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic step,
    output logic pressed
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] c_stable_last = CW'(STABLE_CYCLES - 1);
    localparam logic [15:0]   c_delay_last  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0]   c_period_last = 16'(REPEAT_PERIOD - 1);
    localparam logic [15:0]   c_timer_max   = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic          r_s1;
    logic          r_s2;
    logic [CW-1:0] r_db_cnt;
    logic          r_pressed;
    logic          r_step;
    logic [15:0]   r_timer;
    state_t        r_state;

    logic          w_toggle;
    logic          w_rise;
    logic          w_fall;
    logic          w_step_nxt;
    logic [15:0]   w_timer_nxt;
    state_t        w_state_nxt;

    assign w_toggle = (r_s2 != r_pressed) && (r_db_cnt == c_stable_last);
    assign w_rise   = w_toggle & ~r_pressed;
    assign w_fall   = w_toggle &  r_pressed;

    // Synchroniser and debounce counter; the counter only runs while the
    // synchronised level disagrees with the debounced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_db_cnt  <= '0;
            r_pressed <= 1'b0;
        end else begin
            r_s1 <= btn;
            r_s2 <= r_s1;
            if (r_s2 != r_pressed) begin
                if (r_db_cnt == c_stable_last) begin
                    r_pressed <= ~r_pressed;
                    r_db_cnt  <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_step  <= w_step_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_step_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = DELAY;
                    w_timer_nxt = '0;
                    w_step_nxt  = 1'b1;
                end
            end
            DELAY: begin
                // Release wins over any pulse that would be due this edge.
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end else if (REPEAT_EN != 0) begin
                    if (r_timer == c_delay_last) begin
                        w_state_nxt = REPEAT;
                        w_timer_nxt = '0;
                        w_step_nxt  = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + 16'd1;
                    end
                end else if (r_timer != c_timer_max) begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            REPEAT: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end else if (r_timer == c_period_last) begin
                    w_timer_nxt = '0;
                    w_step_nxt  = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    assign step    = r_step;
    assign pressed = r_pressed;

endmodule

`default_nettype wire

// File: tb/tb_step_debounce.sv
// ============================================================================
//  Module   : tb_step_debounce
//  Purpose  : Scoreboard bench for step_debounce (repeat and no-repeat builds).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_step_debounce;

    logic clk = 1'b0;
    logic reset;
    logic btn;
    logic step1, pressed1;
    logic step0, pressed0;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int cnt1    = 0;
    int q1[$];
    int q0[$];

    step_debounce #(
        .STABLE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut1 (
        .clk(clk), .reset(reset), .btn(btn), .step(step1), .pressed(pressed1)
    );

    step_debounce #(
        .STABLE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut0 (
        .clk(clk), .reset(reset), .btn(btn), .step(step0), .pressed(pressed0)
    );

    always #5 clk = ~clk;

    // cyc equals the index of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0: seg7 = 7'b1111110;
            4'd1: seg7 = 7'b0110000;
            4'd2: seg7 = 7'b1101101;
            4'd3: seg7 = 7'b1111001;
            4'd4: seg7 = 7'b0110011;
            4'd5: seg7 = 7'b1011011;
            4'd6: seg7 = 7'b1011111;
            4'd7: seg7 = 7'b1110000;
            4'd8: seg7 = 7'b1111111;
            4'd9: seg7 = 7'b1111011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    // Monitor: every pulse must match the oldest expected edge index.
    always @(negedge clk) begin
        if (step1) begin
            cnt1 = cnt1 + 1;
            if (q1.size() == 0) check("step1_unexpected", 1, 0);
            else                check("step1_edge", cyc, q1.pop_front());
        end
        if (step0) begin
            if (q0.size() == 0) check("step0_unexpected", 1, 0);
            else                check("step0_edge", cyc, q0.pop_front());
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drained(input string name);
        check({name, "_q1_left"}, q1.size(), 0);
        check({name, "_q0_left"}, q0.size(), 0);
    endtask

    initial begin
        int k, r, f, t0, base;

        // Reset held with the button pressed.
        reset = 1'b1;
        btn   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_step1", step1, 0);
            check("rst_pressed1", pressed1, 0);
        end
        reset = 1'b0;
        btn   = 1'b0;
        @(negedge clk);
        check("post_rst_step1", step1, 0);
        check("post_rst_pressed0", pressed0, 0);
        repeat (3) @(negedge clk);

        // Clean press, held 10 cycles.
        k = cyc + 1;
        btn = 1'b1;
        q1.push_back(k + 5);
        q0.push_back(k + 5);
        wait_cyc(k + 4);
        check("press_early_pressed1", pressed1, 0);
        wait_cyc(k + 5);
        check("press_pressed1", pressed1, 1);
        check("press_pressed0", pressed0, 1);
        wait_cyc(k + 9);
        btn = 1'b0;
        r = k + 10;
        wait_cyc(r + 4);
        check("release_early_pressed1", pressed1, 1);
        wait_cyc(r + 5);
        check("release_pressed1", pressed1, 0);
        check("release_pressed0", pressed0, 0);
        repeat (10) @(negedge clk);
        drained("clean");

        // Bounce (3 high / 1 low x5), then hold for auto-repeat.
        for (int i = 0; i < 5; i++) begin
            btn = 1'b1;
            repeat (3) @(negedge clk);
            btn = 1'b0;
            @(negedge clk);
        end
        base = cnt1;
        f  = cyc + 1;
        btn = 1'b1;
        t0 = f + 5;
        q1.push_back(t0);
        q0.push_back(t0);
        for (int n = 0; n < 6; n++) q1.push_back(t0 + 20 + 8 * n);
        wait_cyc(f + 4);
        check("bounce_pressed1", pressed1, 0);
        wait_cyc(t0);
        check("bounce_final_pressed1", pressed1, 1);
        wait_cyc(t0 + 60);
        btn = 1'b0;
        wait_cyc(t0 + 66);
        check("repeat_release_pressed1", pressed1, 0);
        wait_cyc(t0 + 80);
        check("repeat_pulse_count", cnt1 - base, 7);
        drained("repeat");

        // Release so the fall coincides with a due repeat pulse.
        k  = cyc + 1;
        btn = 1'b1;
        t0 = k + 5;
        q1.push_back(t0);
        q0.push_back(t0);
        q1.push_back(t0 + 20);
        wait_cyc(t0 + 22);
        btn = 1'b0;
        wait_cyc(t0 + 27);
        check("near_due_pressed1", pressed1, 1);
        wait_cyc(t0 + 28);
        check("near_due_step1", step1, 0);
        check("near_due_fall_pressed1", pressed1, 0);
        wait_cyc(t0 + 45);
        drained("near_due");

        // Reset in the middle of a repeating hold.
        k  = cyc + 1;
        btn = 1'b1;
        t0 = k + 5;
        q1.push_back(t0);
        q0.push_back(t0);
        q1.push_back(t0 + 20);
        wait_cyc(t0 + 24);
        reset = 1'b1;
        wait_cyc(t0 + 25);
        check("midrst_step1", step1, 0);
        check("midrst_pressed1", pressed1, 0);
        check("midrst_pressed0", pressed0, 0);
        reset = 1'b0;
        q1.push_back(t0 + 31);
        q0.push_back(t0 + 31);
        wait_cyc(t0 + 31);
        check("midrst_repress_pressed1", pressed1, 1);
        wait_cyc(t0 + 33);
        btn = 1'b0;
        wait_cyc(t0 + 45);
        check("midrst_release_pressed1", pressed1, 0);
        drained("midrst");

        // Three clean presses into a downstream counter.
        cnt1 = 0;
        for (int p = 0; p < 3; p++) begin
            k = cyc + 1;
            btn = 1'b1;
            q1.push_back(k + 5);
            q0.push_back(k + 5);
            repeat (8) @(negedge clk);
            btn = 1'b0;
            repeat (8) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("counter_value", cnt1, 3);
        check("counter_seg", int'(seg7(4'(cnt1))), int'(7'b1111001));
        drained("integration");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
